// File: rtl/ov5640_cfg_pkg.sv
// Shared types and constants for the OV5640 power-up / register-table sequencer.
package ov5640_cfg_pkg;

    // Table entries carrying this address are waits, not register writes.
    localparam logic [15:0] DELAY_MARKER = 16'hFFFF;

    // One table word is {addr[15:0], data[7:0]}.
    localparam int ENTRY_W = 24;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } cfg_entry_t;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PWDN     = 4'd1,
        ST_RST      = 4'd2,
        ST_INIT     = 4'd3,
        ST_FETCH    = 4'd4,
        ST_ISSUE    = 4'd5,
        ST_WAIT_ACK = 4'd6,
        ST_VERIFY   = 4'd7,
        ST_DELAY    = 4'd8,
        ST_NEXT     = 4'd9,
        ST_DONE     = 4'd10,
        ST_ERROR    = 4'd11
    } cfg_state_e;

    // Number of clock cycles in one millisecond.
    function automatic int ms_tick(input int clk_freq_hz);
        return clk_freq_hz / 1000;
    endfunction

endpackage

// File: rtl/ov5640_cfg_seq_if.sv
// SCCB-side request/response bundle of the configuration sequencer.
// The read pair exists only when CAM_CFG_VERIFY_EN is defined.
interface ov5640_cfg_seq_if;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_done;
    logic        wr_nack;
`ifdef CAM_CFG_VERIFY_EN
    logic        rd_req;
    logic [7:0]  rd_data;
`endif

    // Sequencer side: issues requests, receives completion.
    modport master (
        output wr_req, wr_addr, wr_data,
`ifdef CAM_CFG_VERIFY_EN
        output rd_req,
        input  rd_data,
`endif
        input  wr_done, wr_nack
    );

    // SCCB master side: executes requests, reports completion.
    modport slave (
        input  wr_req, wr_addr, wr_data,
`ifdef CAM_CFG_VERIFY_EN
        input  rd_req,
        output rd_data,
`endif
        output wr_done, wr_nack
    );
endinterface

// File: rtl/cfg_ms_timer.sv
// Millisecond wait timer: a cycle prescaler plus a millisecond down-counter.
// load_i marks the first cycle of a wait; expired_o is high on the last one,
// so a wait of N ms lasts exactly N*TICK cycles and a 0 ms wait lasts 1 cycle.
module cfg_ms_timer #(
    parameter int TICK = 27000,
    parameter int MS_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            load_i,
    input  logic [MS_W-1:0] ms_i,
    output logic            expired_o
);
    localparam logic [31:0] TICK_C = 32'(TICK);

    // rem_q: cycles still to run in the current millisecond, including this one
    logic [31:0]     rem_q;
    // ms_q: milliseconds still to run, including the current one
    logic [MS_W-1:0] ms_q;

    // Last-cycle detection; on the load cycle the registers are stale, so use ms_i.
    always_comb begin
        if (load_i) begin
            expired_o = (ms_i == '0) || ((ms_i == MS_W'(1)) && (TICK_C == 32'd1));
        end else begin
            expired_o = (ms_q == '0) || ((ms_q == MS_W'(1)) && (rem_q == 32'd1));
        end
    end

    // Prescaler and millisecond counter; the load cycle already consumes one cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rem_q <= 32'd0;
            ms_q  <= '0;
        end else if (load_i) begin
            if (TICK_C == 32'd1) begin
                rem_q <= 32'd1;
                ms_q  <= ms_i - MS_W'(1);
            end else begin
                rem_q <= TICK_C - 32'd1;
                ms_q  <= ms_i;
            end
        end else if (rem_q == 32'd1) begin
            rem_q <= TICK_C;
            if (ms_q != '0) begin
                ms_q <= ms_q - MS_W'(1);
            end
        end else if (rem_q != 32'd0) begin
            rem_q <= rem_q - 32'd1;
        end
    end
endmodule

// File: rtl/ov5640_cfg_seq.sv
// OV5640 power-up and register-table sequencer.
// Sequences pwdn/rst_n, then walks {addr16,data8} table entries, issuing each
// as an SCCB write with NACK retry; addr 16'hFFFF entries are millisecond waits.
// Optional build macro CAM_CFG_VERIFY_EN adds a read-back check after each write.
module ov5640_cfg_seq
    import ov5640_cfg_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 27_000_000,
    parameter int T_PWDN_MS   = 5,
    parameter int T_RST_MS    = 1,
    parameter int T_INIT_MS   = 20,
    parameter int TBL_LEN     = 256,
    parameter int IDX_W       = 8,
    parameter int MAX_RETRY   = 3
) (
    input  logic               I_clk,
    input  logic               I_rst_n,
    input  logic               I_start,
    output logic               O_cmos_pwdn,
    output logic               O_cmos_rst_n,
    output logic [IDX_W-1:0]   O_tbl_idx,
    input  logic [ENTRY_W-1:0] I_tbl_data,
    output logic               O_wr_req,
    output logic [15:0]        O_wr_addr,
    output logic [7:0]         O_wr_data,
    input  logic               I_wr_done,
    input  logic               I_wr_nack,
`ifdef CAM_CFG_VERIFY_EN
    output logic               O_rd_req,
    input  logic [7:0]         I_rd_data,
    output logic [7:0]         O_verify_err_cnt,
`endif
    output logic               O_busy,
    output logic               O_done,
    output logic               O_error
);
    localparam int               RETRY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TBL_LEN - 1);

    cfg_state_e         state_q;
    logic [IDX_W-1:0]   idx_q;
    cfg_entry_t         ent_q;
    logic [RETRY_W-1:0] retry_q;
    logic               fetch_ph_q;
    logic               pwdn_q;
    logic               cam_rst_n_q;
    logic               wr_req_q;
    logic [15:0]        wr_addr_q;
    logic [7:0]         wr_data_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;
    logic               tmr_load_q;
    logic [15:0]        tmr_ms_q;
    logic               tmr_exp_s;
`ifdef CAM_CFG_VERIFY_EN
    logic               rd_req_q;
    logic [7:0]         verr_cnt_q;
`endif

    cfg_ms_timer #(
        .TICK (ms_tick(CLK_FREQ_HZ)),
        .MS_W (16)
    ) u_ms_timer (
        .clk_i     (I_clk),
        .rst_n_i   (I_rst_n),
        .load_i    (tmr_load_q),
        .ms_i      (tmr_ms_q),
        .expired_o (tmr_exp_s)
    );

    // Sequencer FSM with all outputs registered; timer load is a one-cycle pulse on state entry.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            ent_q       <= '0;
            retry_q     <= '0;
            fetch_ph_q  <= 1'b0;
            pwdn_q      <= 1'b1;
            cam_rst_n_q <= 1'b0;
            wr_req_q    <= 1'b0;
            wr_addr_q   <= 16'h0000;
            wr_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            tmr_load_q  <= 1'b0;
            tmr_ms_q    <= 16'h0000;
`ifdef CAM_CFG_VERIFY_EN
            rd_req_q    <= 1'b0;
            verr_cnt_q  <= 8'h00;
`endif
        end else begin
            tmr_load_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    state_q     <= ST_PWDN;
                    busy_q      <= 1'b1;
                    pwdn_q      <= 1'b1;
                    cam_rst_n_q <= 1'b0;
                    tmr_load_q  <= 1'b1;
                    tmr_ms_q    <= 16'(T_PWDN_MS);
                end
                ST_PWDN: begin
                    if (tmr_exp_s) begin
                        state_q    <= ST_RST;
                        pwdn_q     <= 1'b0;
                        tmr_load_q <= 1'b1;
                        tmr_ms_q   <= 16'(T_RST_MS);
                    end
                end
                ST_RST: begin
                    if (tmr_exp_s) begin
                        state_q     <= ST_INIT;
                        cam_rst_n_q <= 1'b1;
                        tmr_load_q  <= 1'b1;
                        tmr_ms_q    <= 16'(T_INIT_MS);
                    end
                end
                ST_INIT: begin
                    if (tmr_exp_s) begin
                        state_q    <= ST_FETCH;
                        fetch_ph_q <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    // First cycle presents the index, second cycle captures the table word.
                    if (!fetch_ph_q) begin
                        fetch_ph_q <= 1'b1;
                    end else begin
                        ent_q <= cfg_entry_t'(I_tbl_data);
                        if (I_tbl_data[23:8] == DELAY_MARKER) begin
                            state_q    <= ST_DELAY;
                            tmr_load_q <= 1'b1;
                            tmr_ms_q   <= {8'h00, I_tbl_data[7:0]};
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    wr_req_q  <= 1'b1;
                    wr_addr_q <= ent_q.addr;
                    wr_data_q <= ent_q.data;
                    state_q   <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (I_wr_done) begin
                        wr_req_q <= 1'b0;
                        if (!I_wr_nack) begin
`ifdef CAM_CFG_VERIFY_EN
                            rd_req_q <= 1'b1;
                            state_q  <= ST_VERIFY;
`else
                            retry_q  <= '0;
                            state_q  <= ST_NEXT;
`endif
                        end else if (retry_q < RETRY_MAX) begin
                            retry_q <= retry_q + RETRY_W'(1);
                            state_q <= ST_ISSUE;
                        end else begin
                            state_q <= ST_ERROR;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
`ifdef CAM_CFG_VERIFY_EN
                ST_VERIFY: begin
                    // Read-back of the address just written; a NACK or mismatch retries the write.
                    if (I_wr_done) begin
                        rd_req_q <= 1'b0;
                        if (!I_wr_nack && (I_rd_data == wr_data_q)) begin
                            retry_q <= '0;
                            state_q <= ST_NEXT;
                        end else begin
                            if (!I_wr_nack && (verr_cnt_q != 8'hFF)) begin
                                verr_cnt_q <= verr_cnt_q + 8'd1;
                            end
                            if (retry_q < RETRY_MAX) begin
                                retry_q <= retry_q + RETRY_W'(1);
                                state_q <= ST_ISSUE;
                            end else begin
                                state_q <= ST_ERROR;
                                error_q <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
`endif
                ST_DELAY: begin
                    if (tmr_exp_s) begin
                        state_q <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q      <= idx_q + IDX_W'(1);
                        state_q    <= ST_FETCH;
                        fetch_ph_q <= 1'b0;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    // Restart re-powers the camera and walks the table from entry 0.
                    if (I_start) begin
                        state_q     <= ST_PWDN;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        idx_q       <= '0;
                        retry_q     <= '0;
                        pwdn_q      <= 1'b1;
                        cam_rst_n_q <= 1'b0;
                        tmr_load_q  <= 1'b1;
                        tmr_ms_q    <= 16'(T_PWDN_MS);
`ifdef CAM_CFG_VERIFY_EN
                        verr_cnt_q  <= 8'h00;
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign O_cmos_pwdn  = pwdn_q;
    assign O_cmos_rst_n = cam_rst_n_q;
    assign O_tbl_idx    = idx_q;
    assign O_wr_req     = wr_req_q;
    assign O_wr_addr    = wr_addr_q;
    assign O_wr_data    = wr_data_q;
    assign O_busy       = busy_q;
    assign O_done       = done_q;
    assign O_error      = error_q;
`ifdef CAM_CFG_VERIFY_EN
    assign O_rd_req         = rd_req_q;
    assign O_verify_err_cnt = verr_cnt_q;
`endif
endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// Directed bench for ov5640_cfg_seq: 10 kHz clock (10 cycles per ms), 3-entry table,
// scripted SCCB responder answering 4 cycles after each request.
module tb_ov5640_cfg_seq;
    localparam int CLK_FREQ_HZ = 10_000;
    localparam int TBL_LEN     = 3;
    localparam int IDX_W       = 2;

    logic             I_clk = 1'b0;
    logic             I_rst_n;
    logic             I_start;
    logic             O_cmos_pwdn;
    logic             O_cmos_rst_n;
    logic [IDX_W-1:0] O_tbl_idx;
    logic [23:0]      tbl_data;
    logic             O_busy;
    logic             O_done;
    logic             O_error;
    logic [23:0]      tbl_mem [0:TBL_LEN-1];
`ifdef CAM_CFG_VERIFY_EN
    logic [7:0]       verify_err_cnt;
    logic [7:0]       rd_bad_q [$];
`endif

    ov5640_cfg_seq_if sccb();

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [15:0] log_addr [$];
    logic [7:0]  log_data [$];
    int          log_rise [$];
    int          log_fall [$];
    logic        nack_q [$];
    int          busy_rise_cyc  = 0;
    int          pwdn_fall_cyc  = 0;
    int          rstn_rise_cyc  = 0;
    logic        req_prev  = 1'b0;
    logic        busy_prev = 1'b0;
    logic        pwdn_prev = 1'b1;
    logic        rstn_prev = 1'b0;

    always #5 I_clk = ~I_clk;

    ov5640_cfg_seq #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .T_PWDN_MS   (5),
        .T_RST_MS    (1),
        .T_INIT_MS   (20),
        .TBL_LEN     (TBL_LEN),
        .IDX_W       (IDX_W),
        .MAX_RETRY   (3)
    ) dut (
        .I_clk            (I_clk),
        .I_rst_n          (I_rst_n),
        .I_start          (I_start),
        .O_cmos_pwdn      (O_cmos_pwdn),
        .O_cmos_rst_n     (O_cmos_rst_n),
        .O_tbl_idx        (O_tbl_idx),
        .I_tbl_data       (tbl_data),
        .O_wr_req         (sccb.wr_req),
        .O_wr_addr        (sccb.wr_addr),
        .O_wr_data        (sccb.wr_data),
        .I_wr_done        (sccb.wr_done),
        .I_wr_nack        (sccb.wr_nack),
`ifdef CAM_CFG_VERIFY_EN
        .O_rd_req         (sccb.rd_req),
        .I_rd_data        (sccb.rd_data),
        .O_verify_err_cnt (verify_err_cnt),
`endif
        .O_busy           (O_busy),
        .O_done           (O_done),
        .O_error          (O_error)
    );

    // Reset-value image of every output: pwdn=1, all else 0.
    wire [31:0] outs_w = {O_cmos_pwdn, O_cmos_rst_n, sccb.wr_req, O_busy, O_done, O_error,
                          O_tbl_idx, sccb.wr_addr, sccb.wr_data};
`ifdef CAM_CFG_VERIFY_EN
    wire bus_req = sccb.wr_req | sccb.rd_req;
`else
    wire bus_req = sccb.wr_req;
`endif

    // Table ROM model with one cycle of read latency.
    always @(posedge I_clk) tbl_data <= tbl_mem[O_tbl_idx];

    always @(posedge I_clk) cyc <= cyc + 1;

    // Event logger: write-request edges and pin transitions, stamped with the cycle count.
    always @(negedge I_clk) begin
        if (sccb.wr_req && !req_prev) begin
            log_addr.push_back(sccb.wr_addr);
            log_data.push_back(sccb.wr_data);
            log_rise.push_back(cyc);
        end
        if (!sccb.wr_req && req_prev) log_fall.push_back(cyc);
        if (O_busy && !busy_prev) busy_rise_cyc <= cyc;
        if (!O_cmos_pwdn && pwdn_prev) pwdn_fall_cyc <= cyc;
        if (O_cmos_rst_n && !rstn_prev) rstn_rise_cyc <= cyc;
        req_prev  <= sccb.wr_req;
        busy_prev <= O_busy;
        pwdn_prev <= O_cmos_pwdn;
        rstn_prev <= O_cmos_rst_n;
    end

    // SCCB responder: one-cycle done pulse 4 cycles after a request, NACK taken from the script.
    initial begin
        sccb.wr_done = 1'b0;
        sccb.wr_nack = 1'b0;
`ifdef CAM_CFG_VERIFY_EN
        sccb.rd_data = 8'h00;
`endif
        forever begin
            @(posedge bus_req);
            repeat (4) @(negedge I_clk);
            if (bus_req) begin
                sccb.wr_done = 1'b1;
                sccb.wr_nack = 1'b0;
                if (sccb.wr_req && nack_q.size() > 0) sccb.wr_nack = nack_q.pop_front();
`ifdef CAM_CFG_VERIFY_EN
                if (sccb.rd_req)
                    sccb.rd_data = (rd_bad_q.size() > 0) ? rd_bad_q.pop_front() : sccb.wr_data;
`endif
                @(negedge I_clk);
                sccb.wr_done = 1'b0;
                sccb.wr_nack = 1'b0;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait for done or error, bounded; an expired bound counts as a failed vector.
    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!(O_done || O_error) && n < 3000) begin
            @(negedge I_clk);
            n++;
        end
        check_val(tag, 32'(O_done || O_error), 32'd1);
    endtask

    task automatic pulse_start();
        I_start = 1'b1;
        @(negedge I_clk);
        I_start = 1'b0;
    endtask

    initial begin
        int rel;
        int n0;
        int f0;
        int gap;
        int n;
        I_rst_n = 1'b0;
        I_start = 1'b0;
        tbl_mem[0] = 24'h3008_82;
        tbl_mem[1] = 24'hFFFF_02;
        tbl_mem[2] = 24'h3103_03;
        repeat (3) @(negedge I_clk);
        check_val("reset_outs", outs_w, 32'h8000_0000);

        // Power-up timing and the basic 3-entry table.
        n0 = log_addr.size();
        f0 = log_fall.size();
        rel = cyc;
        I_rst_n = 1'b1;
        wait_end("run1_end");
        check_val("busy_rise", 32'(busy_rise_cyc - rel), 32'd1);
        check_val("pwdn_hold", 32'(pwdn_fall_cyc - busy_rise_cyc), 32'd50);
        check_val("rst_hold", 32'(rstn_rise_cyc - pwdn_fall_cyc), 32'd10);
        gap = (log_rise.size() > n0) ? log_rise[n0] - rstn_rise_cyc : 0;
        check_val("init_wait", 32'((gap >= 200) && (gap <= 205)), 32'd1);
        check_val("run1_nwr", 32'(log_addr.size() - n0), 32'd2);
        if (log_addr.size() >= n0 + 2) begin
            check_val("run1_wr0", 32'({log_addr[n0], log_data[n0]}), 32'h0030_0882);
            check_val("run1_wr1", 32'({log_addr[n0+1], log_data[n0+1]}), 32'h0031_0303);
`ifndef CAM_CFG_VERIFY_EN
            // fall->rise: NEXT(1) + FETCH of delay entry(2) + 20 ms-wait + NEXT(1) + FETCH(2) + ISSUE(1)
            check_val("delay_gap", 32'(log_rise[n0+1] - log_fall[f0]), 32'd27);
`endif
        end
        check_val("run1_status", 32'({O_done, O_busy, O_error, O_cmos_pwdn, O_cmos_rst_n}), 32'b10001);
        check_val("run1_idx", 32'(O_tbl_idx), 32'd2);

        // Restart from DONE; entry 0 NACKed twice then accepted.
        nack_q = '{1'b1, 1'b1};
        n0 = log_addr.size();
        pulse_start();
        check_val("restart_pins", 32'({O_cmos_pwdn, O_cmos_rst_n, O_busy, O_done}), 32'b1010);
        wait_end("run2_end");
        check_val("run2_nwr", 32'(log_addr.size() - n0), 32'd4);
        if (log_addr.size() >= n0 + 4) begin
            for (int i = 0; i < 3; i++)
                check_val("run2_retry", 32'({log_addr[n0+i], log_data[n0+i]}), 32'h0030_0882);
            check_val("run2_wr_last", 32'({log_addr[n0+3], log_data[n0+3]}), 32'h0031_0303);
        end
        check_val("run2_status", 32'({O_done, O_error}), 32'b10);

        // Entry 1 NACKed four times -> ERROR with index frozen at 1.
        tbl_mem[1] = 24'h300A_55;
        nack_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        n0 = log_addr.size();
        pulse_start();
        wait_end("run3_end");
        check_val("err_status", 32'({O_done, O_error, O_busy}), 32'b010);
        check_val("err_idx", 32'(O_tbl_idx), 32'd1);
        check_val("err_nwr", 32'(log_addr.size() - n0), 32'd5);
        if (log_addr.size() >= n0 + 5)
            check_val("err_wr_last", 32'({log_addr[n0+4], log_data[n0+4]}), 32'h0030_0A55);

        // Restart from ERROR, then a start pulse while busy must be ignored.
        tbl_mem[1] = 24'hFFFF_02;
        n0 = log_addr.size();
        pulse_start();
        check_val("err_restart", 32'({O_cmos_pwdn, O_error, O_busy, O_tbl_idx}), 32'b10100);
        n = 0;
        while (!O_cmos_rst_n && n < 200) begin
            @(negedge I_clk);
            n++;
        end
        check_val("rerun_rstn", 32'(O_cmos_rst_n), 32'd1);
        repeat (5) @(negedge I_clk);
        pulse_start();
        check_val("busy_start_ign", 32'({O_busy, O_cmos_rst_n, O_cmos_pwdn}), 32'b110);
        wait_end("run4_end");
        check_val("run4_nwr", 32'(log_addr.size() - n0), 32'd2);
        if (log_addr.size() >= n0 + 1)
            check_val("run4_wr0", 32'({log_addr[n0], log_data[n0]}), 32'h0030_0882);
        check_val("run4_done", 32'({O_done, O_error}), 32'b10);

        // Reset asserted while a write is outstanding.
        pulse_start();
        n = 0;
        while (!sccb.wr_req && n < 1000) begin
            @(negedge I_clk);
            n++;
        end
        check_val("mid_req", 32'(sccb.wr_req), 32'd1);
        I_rst_n = 1'b0;
        @(negedge I_clk);
        check_val("mid_reset_outs", outs_w, 32'h8000_0000);
        repeat (8) @(negedge I_clk);
        check_val("reset_hold_outs", outs_w, 32'h8000_0000);

`ifdef CAM_CFG_VERIFY_EN
        // Read-back 0x81 for a 0x82 write retries the entry and counts one mismatch.
        rd_bad_q.push_back(8'h81);
        n0 = log_addr.size();
        I_rst_n = 1'b1;
        wait_end("vfy_end");
        check_val("vfy_cnt", 32'(verify_err_cnt), 32'd1);
        check_val("vfy_nwr", 32'(log_addr.size() - n0), 32'd3);
        check_val("vfy_done", 32'({O_done, O_error}), 32'b10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ov5640_cfg_seq.md
Name: ov5640_cfg_seq

Overview:
Power-up and register-configuration sequencer for the OV5640 camera.
- Drives cmos_pwdn and cmos_rst_n with the required power-up timing.
- Walks an external register table of {addr16, data8} entries and issues each entry as a write request to an SCCB master.
- Raises done or error status.
- Sits in the cmos_clk/I_clk domain beside the SCCB master, ahead of the camera capture path.

Parameters:
CLK_FREQ_HZ, 27_000_000, I_clk frequency; ms tick = CLK_FREQ_HZ/1000 cycles
T_PWDN_MS, 5, time pwdn held high after sequence start
T_RST_MS, 1, time rst_n held low after pwdn release
T_INIT_MS, 20, wait after rst_n release before first SCCB write
TBL_LEN, 256, number of table entries
IDX_W, 8, table index width, clog2(TBL_LEN)
MAX_RETRY, 3, NACK retries per entry before error

Ports:
I_clk  in  1  system clock
I_rst_n  in  1  synchronous reset, active low
I_start  in  1  restart pulse; honoured only in DONE or ERROR
O_cmos_pwdn  out  1  camera power-down
O_cmos_rst_n  out  1  camera reset
O_tbl_idx  out  IDX_W  table read index
I_tbl_data  in  24  {addr[15:0], data[7:0]}; valid 1 cycle after O_tbl_idx changes
O_wr_req  out  1  SCCB write request
O_wr_addr  out  16  register address
O_wr_data  out  8  register data
I_wr_done  in  1  1-cycle pulse, transaction finished
I_wr_nack  in  1  NACK flag, qualified by I_wr_done
O_busy  out  1  sequence in progress
O_done  out  1  table completed without error
O_error  out  1  retries exhausted

Behaviour:
- Reset values:
  - O_cmos_pwdn=1, O_cmos_rst_n=0
  - O_wr_req=0, O_wr_addr=0, O_wr_data=0, O_tbl_idx=0
  - O_busy=0, O_done=0, O_error=0
  - state=IDLE; timer and retry count cleared
- States: IDLE, PWDN, RST, INIT, FETCH, ISSUE, WAIT_ACK, DELAY, NEXT, DONE, ERROR.
- IDLE -> PWDN unconditionally, one cycle after reset release.
  - O_busy=1 from PWDN until DONE or ERROR is entered.
- PWDN: pwdn=1, rst_n=0 for T_PWDN_MS ticks.
- RST: pwdn=0, rst_n=0 for T_RST_MS ticks.
- INIT: rst_n=1 for T_INIT_MS ticks.
- Timer:
  - Ms prescaler restarts on every state entry, so each wait is exactly N*CLK_FREQ_HZ/1000 cycles.
  - A wait of 0 ms exits after 1 cycle.
- FETCH: drive O_tbl_idx; capture I_tbl_data on the following cycle.
- Delay entries: addr==16'hFFFF -> DELAY for data ms; no bus activity; data=0 passes through in 1 cycle.
- ISSUE: load O_wr_addr/O_wr_data, assert O_wr_req.
- WAIT_ACK:
  - O_wr_req, addr and data held stable until I_wr_done is sampled.
  - O_wr_req deasserts the cycle after.
  - I_wr_done with I_wr_nack=0 -> NEXT; retry count cleared.
  - I_wr_done with I_wr_nack=1 and retries<MAX_RETRY -> ISSUE with the same entry, retry+1.
  - I_wr_done with I_wr_nack=1 and retries==MAX_RETRY -> ERROR.
- NEXT:
  - idx==TBL_LEN-1 -> DONE.
  - Otherwise idx+1 -> FETCH.
  - Index never wraps.
- DONE: O_done=1, O_busy=0; pwdn and rst_n remain 0 and 1.
- ERROR: O_error=1, O_busy=0, O_tbl_idx frozen at the failing entry.
- I_start:
  - In DONE or ERROR: clears done and error, idx=0, -> PWDN. The camera is re-powered.
  - In any other state: ignored.
- I_wr_done outside WAIT_ACK is ignored.
- Reset mid-operation: immediate return to reset values.
  - O_wr_req drops in the same cycle reset is sampled.
  - The SCCB master is responsible for aborting its own transfer.

Optional Feature:
CAM_CFG_VERIFY_EN
- Defined:
  - Adds ports O_rd_req (out, 1) and I_rd_data (in, 8), sharing I_wr_done and I_wr_nack.
  - After each acknowledged write, a VERIFY state reads the same address.
  - A mismatch counts as a NACK for retry purposes.
  - An 8-bit O_verify_err_cnt output counts mismatches, saturating at 255 and clearing on restart.
- Undefined: no read traffic, no extra ports; NEXT follows WAIT_ACK directly.

Decomposition:
- Package ov5640_cfg_pkg:
  - state enum
  - DELAY_MARKER=16'hFFFF
  - table entry width 24
  - ms tick function of CLK_FREQ_HZ
- Sub-module cfg_ms_timer:
  - prescaler plus ms down-counter
  - load/start and expired interface
  - reused for all four waits

Test Plan:
CLK_FREQ_HZ=10_000, T_PWDN_MS=5, T_RST_MS=1, T_INIT_MS=20, reset release -> pwdn falls 50 cycles later, rst_n rises 10 cycles after that, first O_wr_req 200+ cycles later.
3-entry table {3008,82},{FFFF,2},{3103,03}, done 4 cycles after each req -> exactly two writes with correct addr/data; 20-cycle gap from the delay entry; O_done=1, O_busy=0.
Entry 0 NACKed twice then ACKed, MAX_RETRY=3 -> three req pulses with the same addr/data; sequence completes, O_error=0.
Entry 1 NACKed 4 times -> ERROR after 4th done, O_tbl_idx=1; I_start -> pwdn=1 next cycle and sequence reruns from idx 0.
I_rst_n low during WAIT_ACK -> all outputs at reset values the next cycle; I_start pulsed while busy -> no effect.
With CAM_CFG_VERIFY_EN, readback 0x81 for write 0x82 -> retry issued, O_verify_err_cnt=1.
